obi_mem_responder: RTL

- Memory-side responder for the core's OBI-style req/gnt/rvalid instruction and data interfaces.
- Accepts requests, performs word-array reads and byte-enabled writes, and returns in-order responses after a configurable minimum latency.
- Has external stall inputs so a bench or formal harness can randomise grant and response timing.
- One instance serves one port. Used in simulation benches and bounded-proof harnesses for instruction or data memory.

---
 rtl/obi_resp_pkg.sv | 15 +
 rtl/obi_resp_fifo.sv | 59 +++++
 rtl/obi_mem_responder.sv | 58 +++++
 3 files changed

// File: rtl/obi_resp_pkg.sv
// obi_resp_pkg: response entry type and address decode helpers for the OBI memory responder
package obi_resp_pkg;
  localparam int unsigned CNT_W = 8;
  typedef struct packed {
    logic [31:0]      rdata;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } obi_resp_entry_t;
  function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base, input int unsigned words);
    return (addr >= base) && (word_index(addr, base) < words);
  endfunction
endpackage

// File: rtl/obi_resp_fifo.sv
// obi_resp_fifo: in-order response queue whose entries count down to their release cycle
module obi_resp_fifo import obi_resp_pkg::*; #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  obi_resp_entry_t entry_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [CW-1:0]   count_o,
  output obi_resp_entry_t head_o
);
  obi_resp_entry_t slot_q [DEPTH];
  obi_resp_entry_t slot_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    slot_d = slot_q;
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i] && slot_q[i].cnt != '0) slot_d[i].cnt = slot_q[i].cnt - 1'b1;
    if (pop_i) vld_d[rd_q] = 1'b0;
    if (push_i) begin
      slot_d[wr_q] = entry_i;
      vld_d[wr_q] = 1'b1;
    end
    wr_d = push_i ? inc(wr_q) : wr_q;
    rd_d = pop_i ? inc(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      slot_q <= '{default: '0};
      vld_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      slot_q <= slot_d;
      vld_q <= vld_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign head_o = slot_q[rd_q];
  assert property (@(posedge clk_i) disable iff (!rst_ni) 32'(wr_q) < DEPTH && 32'(rd_q) < DEPTH);
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o) && !(push_i && full_o));
endmodule

// File: rtl/obi_mem_responder.sv
// obi_mem_responder: OBI req/gnt/rvalid memory model with byte-enabled writes and stallable timing
module obi_mem_responder import obi_resp_pkg::*; #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] MEM_BASE = 32'h1A00_0000,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned RESP_LATENCY = 1,
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1),
  localparam int unsigned IW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  output logic          gnt_o,
  input  logic [31:0]   addr_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic          rvalid_o,
  output logic [31:0]   rdata_o,
  output logic          err_o,
  input  logic          stall_gnt_i,
  input  logic          stall_rvalid_i,
  output logic [CW-1:0] outstanding_o
);
  logic [31:0] mem_q [MEM_WORDS];
  logic full, empty, hit;
  logic [IW-1:0] idx;
  obi_resp_entry_t head, entry;
  assign idx = IW'(word_index(addr_i, MEM_BASE));
  assign hit = in_range(addr_i, MEM_BASE, MEM_WORDS);
  // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot.
  assign gnt_o = rst_ni && req_i && !stall_gnt_i && !full;
  assign rvalid_o = rst_ni && !empty && head.cnt == '0 && !stall_rvalid_i;
  assign rdata_o = rvalid_o ? head.rdata : '0;
  assign err_o = rvalid_o && head.err;
  always_comb begin
    entry.rdata = (hit && !we_i) ? mem_q[idx] : '0;
    entry.err = !hit;
    entry.cnt = CNT_W'(RESP_LATENCY - 1);
  end
  always_ff @(posedge clk_i)
    if (gnt_o && we_i && hit)
      for (int b = 0; b < 4; b++)
        if (be_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
  obi_resp_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (gnt_o),
    .entry_i (entry),
    .pop_i   (rvalid_o),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding_o),
    .head_o  (head)
  );
  assert property (@(posedge clk_i) disable iff (!rst_ni) rvalid_o |-> !empty);
  assert property (@(posedge clk_i) disable iff (!rst_ni) gnt_o |-> req_i);
endmodule
